keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner that replaces the fixed 4x4 externally-counted encoder. It drives the columns itself, synchronises and samples the rows, and debounces whole scan frames. It emits a one-cycle `key_valid` strobe with a binary key code, a held flag, and multi-key detection. It sits between the keypad pads and the display/command logic.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_scanner_if.sv | 25 ++
 rtl/keypad_col_scan.sv | 85 ++++++++
 rtl/keypad_scanner.sv | 131 +++++++++++++
 tb/tb_keypad_scanner.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Holds the FSM and frame-result encodings plus the key code mapping.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } frame_res_t;

  // Code 0 is reserved for the last key so that key (0,0) reads as 1.
  function automatic int key_code_f(int r, int c, int cols, int rows);
    return (r * cols + c + 1) % (rows * cols);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Pad-side and consumer-side signals of the keypad scanner.
// The master modport is the scanner; the slave modport is the keypad/consumer side.
interface keypad_scanner_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int KEY_W = $clog2(ROWS * COLS);

  logic [ROWS-1:0]  row_n;
  logic [COLS-1:0]  col_n;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_held;
  logic             multi_key;

  modport master (
    input  row_n,
    output col_n, key_code, key_valid, key_held, multi_key
  );

  modport slave (
    output row_n,
    input  col_n, key_code, key_valid, key_held, multi_key
  );
endinterface

// File: rtl/keypad_col_scan.sv
// Column driver, row synchroniser and per-frame press accumulator.
// frame_end/frame_res/frame_code are combinational on the last column's sample cycle; no backpressure.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int KEY_W    = $clog2(ROWS * COLS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n,
  output logic             frame_end,
  output frame_res_t       frame_res,
  output logic [KEY_W-1:0] frame_code
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(COLS);

  logic [ROWS-1:0]  row_s1, row_s2;
  logic [DW-1:0]    div;
  logic [CW-1:0]    col, col_nx;
  logic             sample;
  logic [1:0]       acc_hits, hits;
  logic [KEY_W-1:0] acc_code, code;

  assign sample    = (div == DW'(SCAN_DIV - 1));
  assign col_nx    = (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
  assign frame_end = sample && (col == CW'(COLS - 1));

  // Merge this column's presses into the running frame; count saturates at 2.
  always_comb begin
    hits = acc_hits;
    code = acc_code;
    if (sample) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!row_s2[r]) begin
          if (hits == 2'd0) code = KEY_W'(key_code_f(r, int'(col), COLS, ROWS));
          if (hits != 2'd2) hits = hits + 2'd1;
        end
      end
    end
  end

  always_comb begin
    frame_res  = RES_NONE;
    frame_code = code;
    if (hits == 2'd1)      frame_res = RES_SINGLE;
    else if (hits == 2'd2) frame_res = RES_MULTI;
  end

  // Synchroniser clears to all-idle so reset never looks like a press.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_s1   <= '1;
      row_s2   <= '1;
      div      <= '0;
      col      <= '0;
      col_n    <= ~COLS'(1);
      acc_hits <= '0;
      acc_code <= '0;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
      if (sample) begin
        div   <= '0;
        col   <= col_nx;
        col_n <= ~(COLS'(1) << col_nx);
        if (frame_end) begin
          acc_hits <= '0;
          acc_code <= '0;
        end else begin
          acc_hits <= hits;
          acc_code <= code;
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: frame-level debounce with one key_valid strobe per press.
// Outputs update one cycle after each frame-end sample edge; no backpressure.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input logic              clock,
  input logic              reset,
  keypad_scanner_if.master bus
);

  localparam int KEY_W = $clog2(ROWS * COLS);
  localparam int DBW   = $clog2(DEBOUNCE + 1);

  logic             frame_end;
  frame_res_t       frame_res;
  logic [KEY_W-1:0] frame_code;

  kp_state_t        state, state_nx;
  logic [DBW-1:0]   cnt, cnt_nx, cnt_inc;
  logic [KEY_W-1:0] cand, cand_nx;
  logic             accept;
  logic             same_key;

  logic [KEY_W-1:0] key_code_q;
  logic             key_valid_q, key_held_q, multi_q;

  keypad_col_scan #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .KEY_W(KEY_W)
  ) u_scan (
    .clock     (clock),
    .reset     (reset),
    .row_n     (bus.row_n),
    .col_n     (bus.col_n),
    .frame_end (frame_end),
    .frame_res (frame_res),
    .frame_code(frame_code)
  );

  assign cnt_inc  = cnt + DBW'(1);
  assign same_key = (frame_res == RES_SINGLE) && (frame_code == cand);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    accept   = 1'b0;
    if (frame_end) begin
      unique case (state)
        ST_IDLE: begin
          if (frame_res == RES_SINGLE) begin
            cand_nx = frame_code;
            cnt_nx  = DBW'(1);
            if (DEBOUNCE == 1) begin
              state_nx = ST_PRESSED;
              accept   = 1'b1;
            end else begin
              state_nx = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (same_key) begin
            cnt_nx = cnt_inc;
            if (cnt_inc == DBW'(DEBOUNCE)) begin
              state_nx = ST_PRESSED;
              accept   = 1'b1;
            end
          end else if (frame_res == RES_SINGLE) begin
            cand_nx = frame_code;
            cnt_nx  = DBW'(1);
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (!same_key) begin
            // A single empty frame already completes release when DEBOUNCE is 1.
            if (frame_res == RES_NONE && DEBOUNCE == 1) begin
              state_nx = ST_IDLE;
            end else begin
              state_nx = ST_RELEASE;
              cnt_nx   = (frame_res == RES_NONE) ? DBW'(1) : '0;
            end
          end
        end
        ST_RELEASE: begin
          if (frame_res == RES_NONE) begin
            cnt_nx = cnt_inc;
            if (cnt_inc == DBW'(DEBOUNCE)) state_nx = ST_IDLE;
          end else if (same_key) begin
            state_nx = ST_PRESSED;
          end else begin
            cnt_nx = '0;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cand        <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      cand        <= cand_nx;
      key_valid_q <= accept;
      key_held_q  <= (state_nx == ST_PRESSED) || (state_nx == ST_RELEASE);
      if (accept)    key_code_q <= cand_nx;
      if (frame_end) multi_q    <= (frame_res == RES_MULTI);
    end
  end

  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;
  assign bus.multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised and directed frame-level stimulus for keypad_scanner, checked against
// a run-length debounce model of pressed-key masks.
module tb_keypad_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int SDIV  = 4;
  localparam int DEB   = 2;
  localparam int FRAME = COLS * SDIV;

  logic clock;
  logic reset;
  logic [15:0] mask;
  logic [15:0] cur;
  int checks;
  int failures;

  // Reference model state: run length of one single key, empty-frame run while held.
  int m_run, m_last, m_held, m_hkey, m_empty, m_code, m_multi, m_strobe;

  keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE(DEB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad matrix: a pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      bus.row_n[r] = 1'b1;
      for (int c = 0; c < COLS; c++)
        if (mask[r*COLS+c] && !bus.col_n[c]) bus.row_n[r] = 1'b0;
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_last = 0; m_held = 0; m_hkey = 0;
    m_empty = 0; m_code = 0; m_multi = 0; m_strobe = 0;
  endtask

  task automatic model_frame(input logic [15:0] m);
    int hits;
    int first;
    hits = 0;
    first = 0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (m[r*COLS+c]) begin
          if (hits == 0) first = (r * COLS + c + 1) % (ROWS * COLS);
          hits++;
        end
    m_multi  = (hits > 1) ? 1 : 0;
    m_strobe = 0;
    if (m_held == 0) begin
      if (hits == 1) begin
        m_run  = (m_run > 0 && first == m_last) ? m_run + 1 : 1;
        m_last = first;
        if (m_run >= DEB) begin
          m_held = 1; m_hkey = first; m_code = first; m_strobe = 1; m_empty = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (hits == 1 && first == m_hkey) m_empty = 0;
      else if (hits == 0) begin
        m_empty++;
        if (m_empty >= DEB) begin m_held = 0; m_run = 0; end
      end else m_empty = 0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_col_n"}, int'(bus.col_n), 4'b1110);
    check_val({tag, "_key_code"}, int'(bus.key_code), 0);
    check_val({tag, "_key_valid"}, int'(bus.key_valid), 0);
    check_val({tag, "_key_held"}, int'(bus.key_held), 0);
    check_val({tag, "_multi_key"}, int'(bus.multi_key), 0);
  endtask

  // Called #1 after an edge; leaves the bench #1 after the last reset edge, frame-aligned.
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clock);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_frame(input logic [15:0] m);
    int strobes;
    logic [3:0] exp_col;
    mask = m;
    strobes = 0;
    model_frame(m);
    for (int k = 1; k <= FRAME; k++) begin
      @(posedge clock);
      #1;
      exp_col = ~(4'b0001 << ((k / SDIV) % COLS));
      check_val("col_n", int'(bus.col_n), int'(exp_col));
      if (bus.key_valid) strobes++;
    end
    check_val("strobes", strobes, m_strobe);
    check_val("key_code", int'(bus.key_code), m_code);
    check_val("key_held", int'(bus.key_held), m_held);
    check_val("multi_key", int'(bus.multi_key), m_multi);
  endtask

  task automatic run_frames(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) run_frame(m);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    mask = '0;
    cur = '0;
    model_reset();
    #1;
    do_reset(3);

    run_frames(16'h0000, 2);
    // Key (1,2) -> code 7, held then released.
    run_frames(16'h0040, 5);
    check_val("code_1_2", int'(bus.key_code), 7);
    run_frames(16'h0000, 3);
    // Key (3,3) -> code 0, then key (0,0) -> code 1.
    run_frames(16'h8000, 3);
    run_frames(16'h0000, 3);
    run_frames(16'h0001, 3);
    check_val("code_0_0", int'(bus.key_code), 1);
    run_frames(16'h0000, 3);
    // Bouncing key (2,1): present one frame at a time.
    for (int i = 0; i < 3; i++) begin
      run_frame(16'h0200);
      run_frame(16'h0000);
    end
    check_val("bounce_code", int'(bus.key_code), 1);
    // Two keys together, then (0,0) released leaving (2,1).
    run_frames(16'h0201, 3);
    run_frames(16'h0200, 3);
    check_val("code_2_1", int'(bus.key_code), 10);
    run_frames(16'h0000, 3);
    // Reset while pressed, key kept down.
    run_frames(16'h0040, 3);
    do_reset(1);
    run_frames(16'h0040, 3);
    run_frames(16'h0000, 3);

    for (int f = 0; f < 80; f++) begin
      case ($urandom_range(0, 5))
        3: cur = '0;
        4: cur = 16'(1) << $urandom_range(0, 15);
        5: cur = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: cur = cur;
      endcase
      run_frame(cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
